// File: rtl/rv32_imem_arbiter.sv
// Two-requester arbiter for the 8192x32 instruction memory: fetch (read-only) vs loader (r/w).
// Optional RV32_IMEM_ARB_OUTREG_EN adds one output register stage on rvalid/rdata.
module rv32_imem_arbiter #(
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] mem_rdaddress,
  output logic [ADDR_W-1:0] mem_wraddress,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

  logic [7:0]        burst_cnt_q, burst_cnt_d;
  logic              own_if_q, own_if_d;
  logic              own_ld_q, own_ld_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
  logic              fetch_prio;
  logic [ADDR_W-1:0] win_addr;

  // Fetch only outranks the loader once the loader has used up its burst allowance.
  always_comb begin
    fetch_prio = (burst_cnt_q == MaxBurst);
    ld_gnt     = ~reset & ld_req & (~if_req | ~fetch_prio);
    if_gnt     = ~reset & if_req & (~ld_req | fetch_prio);
  end

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (!if_req || if_gnt) begin
      burst_cnt_d = 8'd0;
    end else if (ld_gnt && (burst_cnt_q != MaxBurst)) begin
      burst_cnt_d = burst_cnt_q + 8'd1;
    end
  end

  always_comb begin
    win_addr = '0;
    mem_data = '0;
    if (if_gnt) begin
      win_addr = if_addr;
      mem_data = ld_wdata;
    end else if (ld_gnt) begin
      win_addr = ld_addr;
      mem_data = ld_wdata;
    end
    mem_rdaddress = win_addr;
    mem_wraddress = win_addr;
    mem_wren      = ld_gnt & ld_we;
  end

  // Writes never claim the read-return slot.
  always_comb begin
    own_if_d = if_gnt;
    own_ld_d = ld_gnt & ~ld_we;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      burst_cnt_q <= 8'd0;
      own_if_q    <= 1'b0;
      own_ld_q    <= 1'b0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      own_if_q    <= own_if_d;
      own_ld_q    <= own_ld_d;
    end
  end

  // Each requester's data register keeps its last returned word while not owning the port.
  always_comb begin
    if_rdata_d = own_if_q ? mem_q : if_rdata_q;
    ld_rdata_d = own_ld_q ? mem_q : ld_rdata_q;
  end

`ifdef RV32_IMEM_ARB_OUTREG_EN
  logic if_rvalid_q, ld_rvalid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      if_rvalid_q <= 1'b0;
      ld_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ld_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= own_if_q;
      ld_rvalid_q <= own_ld_q;
      if_rdata_q  <= if_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  always_comb begin
    if_rvalid = ~reset & if_rvalid_q;
    ld_rvalid = ~reset & ld_rvalid_q;
    if_rdata  = reset ? '0 : if_rdata_q;
    ld_rdata  = reset ? '0 : ld_rdata_q;
  end
`else
  always_ff @(posedge clock) begin
    if (reset) begin
      if_rdata_q <= '0;
      ld_rdata_q <= '0;
    end else begin
      if_rdata_q <= if_rdata_d;
      ld_rdata_q <= ld_rdata_d;
    end
  end

  // Reset gating drops a read still in flight when reset lands.
  always_comb begin
    if_rvalid = ~reset & own_if_q;
    ld_rvalid = ~reset & own_ld_q;
    if_rdata  = reset ? '0 : if_rdata_d;
    ld_rdata  = reset ? '0 : ld_rdata_d;
  end
`endif

endmodule
